instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read port. It owns the program counter and drives ReadAddress into the combinational instruction memory. It captures the returned Instruction into an output register and hands it to decode over a valid/ready handshake. It also handles stalls, branch/jump redirects, misaligned or out-of-range targets, and counts delivered instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned and below MEM_BYTES.
MEM_BYTES, 128, size of the instruction memory in bytes (32 words); must be a power of two, at least 4.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  synchronous, active-high reset.
Start  input  1  leave IDLE and begin fetching.
ReadAddress  output  32  byte address to instruction memory; equals the PC register, combinational from that register.
Instruction  input  32  word returned by memory for ReadAddress, same cycle.
FetchValid  output  1  FetchInstruction/FetchPC hold a valid instruction.
FetchReady  input  1  decode accepts the instruction this cycle.
FetchInstruction  output  32  captured instruction word.
FetchPC  output  32  address FetchInstruction was read from.
Redirect  input  1  load a new PC (taken branch or jump).
RedirectTarget  input  32  new PC when Redirect=1.
FetchError  output  1  sticky; set on an illegal redirect target.
InstrCount  output  32  number of completed handshakes (FetchValid && FetchReady).

Behaviour:
- States: IDLE, FETCH, HALT. Registered outputs.
- Reset (overrides everything, including mid-operation): state=IDLE, PC=RESET_PC, FetchValid=0, FetchInstruction=0, FetchPC=0, FetchError=0, InstrCount=0.
- Target legality: legal iff target[1:0]==2'b00 and target < MEM_BYTES.
- IDLE:
  - Start=1 -> FETCH next cycle; no capture in the transition cycle.
  - Redirect=1 with a legal target -> PC<=target, stay IDLE.
  - Redirect=1 with an illegal target -> HALT, FetchError<=1.
  - Redirect has priority over Start in the same cycle.
- FETCH, slot free (FetchValid==0, or FetchValid && FetchReady), no Redirect:
  - FetchInstruction<=Instruction, FetchPC<=PC, FetchValid<=1.
  - PC<=(PC+4) mod MEM_BYTES; wraps from MEM_BYTES-4 to 0.
  - Result: one instruction per cycle with no bubbles while FetchReady=1.
- FETCH stall (FetchValid=1 && FetchReady=0, no Redirect): PC, FetchInstruction, FetchPC and FetchValid all hold; ReadAddress stable.
- FETCH with Redirect=1 (highest priority):
  - No capture that cycle; FetchValid<=0 (flushes the wrong-path instruction).
  - Legal target -> PC<=target, stay FETCH; the first new-path instruction appears with FetchValid=1 two cycles after the Redirect cycle.
  - Illegal target -> HALT, FetchError<=1, PC unchanged.
- Handshake coincident with Redirect: the handshake counts as completed (InstrCount increments); the slot is then cleared as above.
- HALT: FetchValid=0, PC and ReadAddress frozen, Start and Redirect ignored, FetchError stays 1. Only Reset exits.
- InstrCount: increments by 1 on every cycle with FetchValid && FetchReady; wraps modulo 2^32.
- Latency: ReadAddress to FetchValid is 1 cycle; memory is combinational, so no memory wait states.
- Outputs never change while FetchValid=1 && FetchReady=0 (AXI-style stability rule).

Test Plan:
- Reset, Start=1, FetchReady=1 held, memory words 0..3 = 0x00500093, 0x00100113, 0x002081B3, 0x00000013 -> FetchPC 0,4,8,12 on consecutive cycles with the matching words; InstrCount=4 after 4 handshakes.
- FetchReady=0 for 3 cycles while FetchPC=8 -> FetchPC=8, FetchInstruction=0x002081B3, ReadAddress=12 held for all 3 cycles; resumes with FetchPC=12 the cycle after FetchReady=1.
- Redirect=1, RedirectTarget=0x40 while FetchPC=4 is valid -> next cycle FetchValid=0, ReadAddress=0x40; following cycle FetchPC=0x40, FetchValid=1; no instruction from PC 8 is ever delivered.
- Sequential fetch reaching PC=0x7C with MEM_BYTES=128 -> FetchPC=0x7C, then FetchPC=0x00; FetchError stays 0.
- Redirect to 0x42, and separately to 0x80 -> state HALT, FetchError=1, FetchValid=0; Start and further Redirects are ignored until Reset. Reset then restores PC=RESET_PC, FetchError=0, InstrCount=0.
- Redirect and handshake in the same cycle (FetchValid=1, FetchReady=1) -> InstrCount increments once, FetchValid=0 on the next cycle, PC=target.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads a combinational
// instruction memory and hands captured words to decode over valid/ready.
// Handles stalls, branch/jump redirects, illegal targets and counts deliveries.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic [31:0] ReadAddress,
    input  logic [31:0] Instruction,
    output logic        FetchValid,
    input  logic        FetchReady,
    output logic [31:0] FetchInstruction,
    output logic [31:0] FetchPC,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        FetchError,
    output logic [31:0] InstrCount
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [31:0] LP_MEM_BYTES = 32'(MEM_BYTES);
    // MEM_BYTES is a power of two, so wrapping the PC is a simple mask.
    localparam logic [31:0] LP_ADDR_MASK = LP_MEM_BYTES - 32'd1;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_fetch_valid;
    logic [31:0] r_fetch_instr;
    logic [31:0] r_fetch_pc;
    logic        r_fetch_error;
    logic [31:0] r_instr_count;

    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic        w_fetch_valid_next;
    logic [31:0] w_fetch_instr_next;
    logic [31:0] w_fetch_pc_next;
    logic        w_fetch_error_next;
    logic        w_target_legal;
    logic        w_handshake;
    logic        w_slot_free;

    assign w_target_legal = (RedirectTarget[1:0] == 2'b00) && (RedirectTarget < LP_MEM_BYTES);
    assign w_handshake    = r_fetch_valid && FetchReady;
    assign w_slot_free    = !r_fetch_valid || FetchReady;

    // State register and all registered outputs, with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= 32'd0;
            r_fetch_pc    <= 32'd0;
            r_fetch_error <= 1'b0;
            r_instr_count <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_fetch_valid <= w_fetch_valid_next;
            r_fetch_instr <= w_fetch_instr_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_fetch_error <= w_fetch_error_next;
            // A handshake coinciding with a redirect still counts as delivered.
            if (w_handshake) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
        end
    end

    // Next-state and next-value logic; Redirect outranks Start and capture.
    // NOTE: every signal gets a hold default first so no path infers a latch.
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_fetch_valid_next = r_fetch_valid;
        w_fetch_instr_next = r_fetch_instr;
        w_fetch_pc_next    = r_fetch_pc;
        w_fetch_error_next = r_fetch_error;

        unique case (r_state)
            ST_IDLE: begin
                if (Redirect) begin
                    if (w_target_legal) begin
                        w_pc_next = RedirectTarget;
                    end else begin
                        w_state_next       = ST_HALT;
                        w_fetch_error_next = 1'b1;
                    end
                end else if (Start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (Redirect) begin
                    // Flush the wrong-path instruction; no capture this cycle.
                    w_fetch_valid_next = 1'b0;
                    if (w_target_legal) begin
                        w_pc_next = RedirectTarget;
                    end else begin
                        w_state_next       = ST_HALT;
                        w_fetch_error_next = 1'b1;
                    end
                end else if (w_slot_free) begin
                    w_fetch_instr_next = Instruction;
                    w_fetch_pc_next    = r_pc;
                    w_fetch_valid_next = 1'b1;
                    w_pc_next          = (r_pc + 32'd4) & LP_ADDR_MASK;
                end
            end
            ST_HALT: begin
                w_fetch_valid_next = 1'b0;
            end
            default: begin
                w_state_next       = ST_HALT;
                w_fetch_valid_next = 1'b0;
            end
        endcase
    end

    assign ReadAddress      = r_pc;
    assign FetchValid       = r_fetch_valid;
    assign FetchInstruction = r_fetch_instr;
    assign FetchPC          = r_fetch_pc;
    assign FetchError       = r_fetch_error;
    assign InstrCount       = r_instr_count;

endmodule
